// File: rtl/speicher_steuerung_pkg.sv
// Shared types and constants for the CPU memory controller and its SRAM model.
package speicher_paket;

  typedef enum logic [2:0] {
    BEREIT   = 3'd0,
    ZUGRIFF  = 3'd1,
    WARTEN   = 3'd2,
    ANTWORT  = 3'd3,
    FREIGABE = 3'd4
  } zustand_t;

  typedef enum logic [1:0] {
    ZUGRIFF_INSTR     = 2'd0,
    ZUGRIFF_LADEN     = 2'd1,
    ZUGRIFF_SPEICHERN = 2'd2
  } zugriff_t;

  localparam int MAX_LESE_LATENZ = 4;

  // Any address bit at or above the SRAM width means "not backed by memory".
  function automatic logic ausser_bereich(input logic [31:0] adr, input int breite);
    return (adr >> breite) != 32'd0;
  endfunction

endpackage

// File: rtl/speicher_steuerung_modell.sv
// Behavioural single-port synchronous SRAM with a configurable read pipeline.
module speicher_modell #(
  parameter int ADRESS_BREITE = 14,
  parameter int LESE_LATENZ   = 1
) (
  input  logic                     clk_i,
  input  logic [ADRESS_BREITE-1:0] adresse_i,
  input  logic [31:0]              schreibdaten_i,
  input  logic                     aktiv_i,
  input  logic                     schreiben_i,
  output logic [31:0]              lesedaten_o
);

  logic [31:0] mem_q   [2**ADRESS_BREITE];
  logic [31:0] stufe_q [LESE_LATENZ];

  // Read data holds its last value until the next read reaches the output.
  always_ff @(posedge clk_i) begin
    if (aktiv_i && schreiben_i) mem_q[adresse_i] <= schreibdaten_i;
    if (aktiv_i && !schreiben_i) stufe_q[0] <= mem_q[adresse_i];
    for (int i = 1; i < LESE_LATENZ; i++) stufe_q[i] <= stufe_q[i-1];
  end

  assign lesedaten_o = stufe_q[LESE_LATENZ-1];

endmodule

// File: rtl/speicher_steuerung.sv
// Memory responder: arbitrates fetch/load/store requests onto one single-port SRAM
// and answers each with data and a one-cycle completion pulse.
module speicher_steuerung
  import speicher_paket::*;
#(
  parameter int ADRESS_BREITE = 14,
  parameter int LESE_LATENZ   = 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     LeseInstruktion,
  input  logic [31:0]              InstruktionAdresse,
  output logic [31:0]              Instruktion,
  output logic                     InstruktionGeladen,
  input  logic                     LeseDaten,
  input  logic                     SchreibeDaten,
  input  logic [31:0]              DatenAdresse,
  input  logic [31:0]              DatenSchreibwert,
  output logic [31:0]              DatenLesewert,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic [31:0]              SpeicherSchreibDaten,
  output logic                     SpeicherAktiv,
  output logic                     SpeicherSchreiben,
  input  logic [31:0]              SpeicherLeseDaten
);

  localparam int WARTE_W = $clog2(MAX_LESE_LATENZ);
  localparam logic [WARTE_W-1:0] WARTE_START =
    WARTE_W'((LESE_LATENZ > 1) ? (LESE_LATENZ - 2) : 0);

  zustand_t                 zustand_q;
  zugriff_t                 typ_q;
  logic                     ausser_q;
  logic [WARTE_W-1:0]       warte_q;
  logic [31:0]              instr_q, daten_q;
  logic                     ig_q, dg_q, dgs_q;
  logic                     aktiv_q, schreiben_q;
  logic [ADRESS_BREITE-1:0] adresse_q;
  logic [31:0]              schreibdaten_q;

  zugriff_t    typ_d;
  logic [31:0] adr_d;
  logic        anfrage_d, ausser_d, bedient_d;
  logic [31:0] lesewert_d, instr_d, daten_d;

  // Fixed priority: store > load > fetch.
  always_comb begin
    anfrage_d = SchreibeDaten | LeseDaten | LeseInstruktion;
    typ_d     = ZUGRIFF_INSTR;
    adr_d     = InstruktionAdresse;
    if (SchreibeDaten) begin
      typ_d = ZUGRIFF_SPEICHERN;
      adr_d = DatenAdresse;
    end else if (LeseDaten) begin
      typ_d = ZUGRIFF_LADEN;
      adr_d = DatenAdresse;
    end
    ausser_d = ausser_bereich(adr_d, ADRESS_BREITE);
  end

  always_comb begin
    case (typ_q)
      ZUGRIFF_SPEICHERN: bedient_d = SchreibeDaten;
      ZUGRIFF_LADEN:     bedient_d = LeseDaten;
      default:           bedient_d = LeseInstruktion;
    endcase
  end

  // Read data is forwarded straight to the output during ANTWORT so it is valid with the pulse.
  always_comb begin
    lesewert_d = ausser_q ? 32'd0 : SpeicherLeseDaten;
    instr_d    = instr_q;
    daten_d    = daten_q;
    if (zustand_q == ANTWORT && typ_q == ZUGRIFF_INSTR) instr_d = lesewert_d;
    if (zustand_q == ANTWORT && typ_q == ZUGRIFF_LADEN) daten_d = lesewert_d;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      zustand_q      <= BEREIT;
      typ_q          <= ZUGRIFF_INSTR;
      ausser_q       <= 1'b0;
      warte_q        <= '0;
      instr_q        <= '0;
      daten_q        <= '0;
      ig_q           <= 1'b0;
      dg_q           <= 1'b0;
      dgs_q          <= 1'b0;
      aktiv_q        <= 1'b0;
      schreiben_q    <= 1'b0;
      adresse_q      <= '0;
      schreibdaten_q <= '0;
    end else begin
      ig_q        <= 1'b0;
      dg_q        <= 1'b0;
      dgs_q       <= 1'b0;
      aktiv_q     <= 1'b0;
      schreiben_q <= 1'b0;
      case (zustand_q)
        BEREIT: begin
          if (anfrage_d) begin
            typ_q       <= typ_d;
            ausser_q    <= ausser_d;
            adresse_q   <= adr_d[ADRESS_BREITE-1:0];
            aktiv_q     <= !ausser_d;
            schreiben_q <= (typ_d == ZUGRIFF_SPEICHERN) && !ausser_d;
            if (typ_d == ZUGRIFF_SPEICHERN) schreibdaten_q <= DatenSchreibwert;
            zustand_q   <= ZUGRIFF;
          end
        end
        ZUGRIFF: begin
          if (typ_q != ZUGRIFF_SPEICHERN && LESE_LATENZ > 1) begin
            warte_q   <= WARTE_START;
            zustand_q <= WARTEN;
          end else begin
            ig_q      <= (typ_q == ZUGRIFF_INSTR);
            dg_q      <= (typ_q == ZUGRIFF_LADEN);
            dgs_q     <= (typ_q == ZUGRIFF_SPEICHERN);
            zustand_q <= ANTWORT;
          end
        end
        WARTEN: begin
          if (warte_q == '0) begin
            ig_q      <= (typ_q == ZUGRIFF_INSTR);
            dg_q      <= (typ_q == ZUGRIFF_LADEN);
            zustand_q <= ANTWORT;
          end else begin
            warte_q <= warte_q - 1'b1;
          end
        end
        ANTWORT: begin
          instr_q   <= instr_d;
          daten_q   <= daten_d;
          zustand_q <= FREIGABE;
        end
        FREIGABE: begin
          // A level-held request must be released before it can be served again.
          if (!bedient_d) zustand_q <= BEREIT;
        end
        default: zustand_q <= BEREIT;
      endcase
    end
  end

  assign Instruktion          = instr_d;
  assign DatenLesewert        = daten_d;
  assign InstruktionGeladen   = ig_q;
  assign DatenGeladen         = dg_q;
  assign DatenGespeichert     = dgs_q;
  assign SpeicherAdresse      = adresse_q;
  assign SpeicherSchreibDaten = schreibdaten_q;
  assign SpeicherAktiv        = aktiv_q;
  assign SpeicherSchreiben    = schreiben_q;

endmodule

// File: tb/tb_speicher_steuerung.sv
// Scoreboard bench: controller instance 0 with read latency 1, instance 1 with latency 3.
module tb_speicher_steuerung;
  import speicher_paket::*;

  typedef struct {
    zugriff_t    art;
    logic [31:0] wert;
    int          zyk;
  } erw_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          zyk = 0;
  int          total = 0;
  int          bad = 0;

  logic        li [2], ld [2], sd [2];
  logic [31:0] iadr [2], dadr [2], wdat [2];
  logic [31:0] instr [2], dlw [2];
  logic        ig [2], dg [2], dgs [2];
  logic [13:0] sadr [2];
  logic [31:0] swd [2], srd [2];
  logic        sakt [2], sschr [2];

  int          akt_cnt [2];
  int          schr_zyk [2];
  logic [31:0] schr_adr [2], schr_dat [2];

  erw_t sb0 [$];
  erw_t sb1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) zyk <= zyk + 1;

  speicher_steuerung #(.ADRESS_BREITE(14), .LESE_LATENZ(1)) dut0 (
    .Clock(clk), .Reset(rst_n),
    .LeseInstruktion(li[0]), .InstruktionAdresse(iadr[0]), .Instruktion(instr[0]),
    .InstruktionGeladen(ig[0]), .LeseDaten(ld[0]), .SchreibeDaten(sd[0]),
    .DatenAdresse(dadr[0]), .DatenSchreibwert(wdat[0]), .DatenLesewert(dlw[0]),
    .DatenGeladen(dg[0]), .DatenGespeichert(dgs[0]), .SpeicherAdresse(sadr[0]),
    .SpeicherSchreibDaten(swd[0]), .SpeicherAktiv(sakt[0]), .SpeicherSchreiben(sschr[0]),
    .SpeicherLeseDaten(srd[0]));

  speicher_modell #(.ADRESS_BREITE(14), .LESE_LATENZ(1)) mem0 (
    .clk_i(clk), .adresse_i(sadr[0]), .schreibdaten_i(swd[0]), .aktiv_i(sakt[0]),
    .schreiben_i(sschr[0]), .lesedaten_o(srd[0]));

  speicher_steuerung #(.ADRESS_BREITE(14), .LESE_LATENZ(3)) dut1 (
    .Clock(clk), .Reset(rst_n),
    .LeseInstruktion(li[1]), .InstruktionAdresse(iadr[1]), .Instruktion(instr[1]),
    .InstruktionGeladen(ig[1]), .LeseDaten(ld[1]), .SchreibeDaten(sd[1]),
    .DatenAdresse(dadr[1]), .DatenSchreibwert(wdat[1]), .DatenLesewert(dlw[1]),
    .DatenGeladen(dg[1]), .DatenGespeichert(dgs[1]), .SpeicherAdresse(sadr[1]),
    .SpeicherSchreibDaten(swd[1]), .SpeicherAktiv(sakt[1]), .SpeicherSchreiben(sschr[1]),
    .SpeicherLeseDaten(srd[1]));

  speicher_modell #(.ADRESS_BREITE(14), .LESE_LATENZ(3)) mem1 (
    .clk_i(clk), .adresse_i(sadr[1]), .schreibdaten_i(swd[1]), .aktiv_i(sakt[1]),
    .schreiben_i(sschr[1]), .lesedaten_o(srd[1]));

  task automatic pruefe(input string name, input int k, input logic [31:0] ist,
                        input logic [31:0] soll);
    total++;
    if (ist !== soll) begin
      bad++;
      $display("FAIL %s dut%0d: ist=%h soll=%h", name, k, ist, soll);
    end
  endtask

  function automatic void erwarte(input int k, input erw_t e);
    if (k == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endfunction

  function automatic int fuellstand(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic erw_t hole(input int k);
    if (k == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  function automatic logic [2:0] puls_code(input zugriff_t art);
    case (art)
      ZUGRIFF_INSTR: return 3'b100;
      ZUGRIFF_LADEN: return 3'b010;
      default:       return 3'b001;
    endcase
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_mon
    always @(posedge clk) if (sakt[k]) akt_cnt[k] <= akt_cnt[k] + 1;

    always @(negedge clk) begin
      logic [2:0] p;
      erw_t       e;
      p = {ig[k], dg[k], dgs[k]};
      if (sakt[k] && sschr[k]) begin
        schr_zyk[k] = zyk;
        schr_adr[k] = 32'(sadr[k]);
        schr_dat[k] = swd[k];
      end
      if (p != 3'b000) begin
        pruefe("puls_exklusiv", k, 32'($countones(p)), 32'd1);
        if (fuellstand(k) == 0) begin
          total++;
          bad++;
          $display("FAIL unerwarteter_puls dut%0d: ist=%b soll=kein_puls", k, p);
        end else begin
          e = hole(k);
          pruefe("puls_art", k, 32'(p), 32'(puls_code(e.art)));
          if (e.art == ZUGRIFF_INSTR) pruefe("instruktion", k, instr[k], e.wert);
          if (e.art == ZUGRIFF_LADEN) pruefe("lesewert", k, dlw[k], e.wert);
          if (e.zyk >= 0) pruefe("latenz", k, 32'(zyk), 32'(e.zyk));
        end
      end
    end
  end

  task automatic warte_puls(input int k);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ig[k] || dg[k] || dgs[k]) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout dut%0d: ist=kein_puls soll=puls", k);
    end
  endtask

  // Called at a falling edge with the controller idle; returns at a falling edge, idle again.
  task automatic auftrag(input int k, input zugriff_t art, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] soll,
                         input int versatz, input int halte);
    erw_t e;
    e.art  = art;
    e.wert = soll;
    e.zyk  = zyk + versatz;
    erwarte(k, e);
    case (art)
      ZUGRIFF_INSTR: begin li[k] = 1'b1; iadr[k] = adr; end
      ZUGRIFF_LADEN: begin ld[k] = 1'b1; dadr[k] = adr; end
      default:       begin sd[k] = 1'b1; dadr[k] = adr; wdat[k] = wd; end
    endcase
    warte_puls(k);
    repeat (halte) @(negedge clk);
    li[k] = 1'b0;
    ld[k] = 1'b0;
    sd[k] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pruefe_null(input int k);
    pruefe("reset_instruktion", k, instr[k], 32'd0);
    pruefe("reset_lesewert", k, dlw[k], 32'd0);
    pruefe("reset_pulse", k, 32'({ig[k], dg[k], dgs[k]}), 32'd0);
    pruefe("reset_aktiv", k, 32'(sakt[k]), 32'd0);
    pruefe("reset_schreiben", k, 32'(sschr[k]), 32'd0);
    pruefe("reset_adresse", k, 32'(sadr[k]), 32'd0);
    pruefe("reset_schreibdaten", k, swd[k], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: ist=haengt soll=ende");
    $fatal(1);
  end

  initial begin
    int   d;
    int   a0;
    erw_t e;
    for (int k = 0; k < 2; k++) begin
      li[k] = 1'b0; ld[k] = 1'b0; sd[k] = 1'b0;
      iadr[k] = '0; dadr[k] = '0; wdat[k] = '0;
      akt_cnt[k] = 0; schr_zyk[k] = -1; schr_adr[k] = '0; schr_dat[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    pruefe_null(0);
    pruefe_null(1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency 1: preload, fetch held past completion, store/load round trip
    auftrag(0, ZUGRIFF_SPEICHERN, 32'h10, 32'hDEADBEEF, 32'h0, 2, 0);
    auftrag(0, ZUGRIFF_INSTR, 32'h10, 32'h0, 32'hDEADBEEF, 2, 4);
    pruefe("instruktion_gehalten", 0, instr[0], 32'hDEADBEEF);

    d = zyk;
    auftrag(0, ZUGRIFF_SPEICHERN, 32'h3, 32'h12345678, 32'h0, 2, 0);
    pruefe("schreib_zyklus", 0, 32'(schr_zyk[0]), 32'(d + 1));
    pruefe("schreib_adresse", 0, schr_adr[0], 32'h3);
    pruefe("schreib_daten", 0, schr_dat[0], 32'h12345678);
    auftrag(0, ZUGRIFF_LADEN, 32'h3, 32'h0, 32'h12345678, 2, 0);
    pruefe("instruktion_unberuehrt", 0, instr[0], 32'hDEADBEEF);

    // Store and fetch requested together: store first, fetch after store is released
    auftrag(0, ZUGRIFF_SPEICHERN, 32'h20, 32'h0BADF00D, 32'h0, 2, 0);
    d = zyk;
    e = '{ZUGRIFF_SPEICHERN, 32'h0, d + 2};
    erwarte(0, e);
    e = '{ZUGRIFF_INSTR, 32'h0BADF00D, d + 6};
    erwarte(0, e);
    sd[0] = 1'b1; dadr[0] = 32'h21; wdat[0] = 32'h11112222;
    li[0] = 1'b1; iadr[0] = 32'h20;
    warte_puls(0);
    sd[0] = 1'b0;
    warte_puls(0);
    li[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Out-of-range addresses never touch the SRAM
    auftrag(0, ZUGRIFF_SPEICHERN, 32'h0, 32'hAAAA5555, 32'h0, 2, 0);
    a0 = akt_cnt[0];
    auftrag(0, ZUGRIFF_LADEN, 32'h00010000, 32'h0, 32'h0, 2, 0);
    auftrag(0, ZUGRIFF_SPEICHERN, 32'h00010000, 32'h5555AAAA, 32'h0, 2, 0);
    pruefe("aktiv_ausser_bereich", 0, 32'(akt_cnt[0] - a0), 32'd0);
    auftrag(0, ZUGRIFF_LADEN, 32'h0, 32'h0, 32'hAAAA5555, 2, 0);

    // Latency 3
    auftrag(1, ZUGRIFF_SPEICHERN, 32'h7, 32'hCAFEF00D, 32'h0, 2, 0);
    a0 = akt_cnt[1];
    auftrag(1, ZUGRIFF_LADEN, 32'h7, 32'h0, 32'hCAFEF00D, 4, 0);
    pruefe("aktiv_einmal", 1, 32'(akt_cnt[1] - a0), 32'd1);
    auftrag(1, ZUGRIFF_INSTR, 32'h7, 32'h0, 32'hCAFEF00D, 4, 0);

    // Reset while the load waits on the SRAM: no completion, everything cleared
    ld[1] = 1'b1;
    dadr[1] = 32'h7;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    pruefe_null(1);
    pruefe_null(0);
    ld[1] = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    auftrag(1, ZUGRIFF_INSTR, 32'h7, 32'h0, 32'hCAFEF00D, 4, 0);

    repeat (3) @(negedge clk);
    pruefe("scoreboard_rest", 0, 32'(sb0.size()), 32'd0);
    pruefe("scoreboard_rest", 1, 32'(sb1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
